// File: rtl/bsg_adder_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bsg_adder_serial_ctrl
// Brief    : Multi-slice adder that reuses one width_p-bit carry adder, one slice per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_adder_serial_ctrl #(
    parameter int width_p = 64,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p*els_p-1:0]   a_i,
    input  logic [width_p*els_p-1:0]   b_i,
    input  logic                       cin_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [width_p*els_p-1:0]   sum_o,
    output logic                       cout_o,
    input  logic                       yumi_i
);

    localparam int K_W   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int OP_W  = width_p * els_p;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               carry_q, carry_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [OP_W-1:0]    res_q, res_d;
    logic [OP_W-1:0]    sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [width_p-1:0] slice_a;
    logic [width_p-1:0] slice_b;
    logic [width_p-1:0] add_s;
    logic               add_c;
    logic               last_slice;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < els_p; i++) begin
            if (int'(k_q) == i) begin
                slice_a = a_q[i*width_p +: width_p];
                slice_b = b_q[i*width_p +: width_p];
            end
        end
        {add_c, add_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{width_p{1'b0}}, carry_q};
        last_slice     = (int'(k_q) == els_p - 1);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (v_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < els_p; i++) begin
                    if (int'(k_q) == i) begin
                        res_d[i*width_p +: width_p] = add_s;
                    end
                end
                carry_d = add_c;
                // Publish the finished result only on entry to DONE so sum_o/cout_o hold otherwise.
                if (last_slice) begin
                    sum_d   = res_d;
                    cout_d  = add_c;
                    state_d = DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            DONE: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign v_o     = (state_q == DONE);
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_adder_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_adder_serial_ctrl
// Brief    : Directed bench for the serial adder, 64x4 and 8x1 configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_adder_serial_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         v_a = 1'b0, cin_a = 1'b0, yumi_a = 1'b0;
    logic [255:0] a_a = '0, b_a = '0;
    logic         ready_a, vo_a, cout_a;
    logic [255:0] sum_a;

    logic         v_b = 1'b0, cin_b = 1'b0, yumi_b = 1'b0;
    logic [7:0]   a_b = '0, b_b = '0;
    logic         ready_b, vo_b, cout_b;
    logic [7:0]   sum_b;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    bsg_adder_serial_ctrl #(.width_p(64), .els_p(4)) u_dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a), .a_i(a_a), .b_i(b_a),
        .cin_i(cin_a), .ready_o(ready_a), .v_o(vo_a), .sum_o(sum_a),
        .cout_o(cout_a), .yumi_i(yumi_a)
    );

    bsg_adder_serial_ctrl #(.width_p(8), .els_p(1)) u_dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_b), .a_i(a_b), .b_i(b_b),
        .cin_i(cin_b), .ready_o(ready_b), .v_o(vo_b), .sum_o(sum_b),
        .cout_o(cout_b), .yumi_i(yumi_b)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the 64x4 instance and wait (bounded) for v_o.
    task automatic run_a(input string tag, input logic [255:0] a, input logic [255:0] b,
                         input logic cin, input logic [255:0] exp_sum, input logic exp_cout);
        int lat;
        chk({tag, "_ready_before"}, {255'd0, ready_a}, 256'd1);
        a_a = a; b_a = b; cin_a = cin; v_a = 1'b1;
        tick();
        v_a = 1'b0;
        lat = 0;
        while (!vo_a && lat < 10) begin
            chk({tag, "_busy_not_ready"}, {255'd0, ready_a}, 256'd0);
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 256'(lat), 256'd4);
        chk({tag, "_sum"}, sum_a, exp_sum);
        chk({tag, "_cout"}, {255'd0, cout_a}, {255'd0, exp_cout});
        chk({tag, "_done_not_ready"}, {255'd0, ready_a}, 256'd0);
    endtask

    initial begin
        logic [255:0] exp3;

        #3;
        chk("rst_ready", {255'd0, ready_a}, 256'd1);
        chk("rst_v", {255'd0, vo_a}, 256'd0);
        chk("rst_sum", sum_a, 256'd0);
        chk("rst_cout", {255'd0, cout_a}, 256'd0);
        chk("rst_b_ready", {255'd0, ready_b}, 256'd1);
        chk("rst_b_v", {255'd0, vo_b}, 256'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // All-ones plus carry-in wraps to zero with carry out
        run_a("allones", {256{1'b1}}, 256'd0, 1'b1, 256'd0, 1'b1);

        // Request presented alongside yumi must not be taken
        yumi_a = 1'b1; v_a = 1'b1; a_a = 256'd1; b_a = 256'd1; cin_a = 1'b0;
        tick();
        yumi_a = 1'b0; v_a = 1'b0;
        chk("yumi_to_idle", {255'd0, ready_a}, 256'd1);
        chk("yumi_no_accept_v", {255'd0, vo_a}, 256'd0);

        run_a("one_plus_one", 256'd1, 256'd1, 1'b0, 256'd2, 1'b0);
        yumi_a = 1'b1;
        tick();
        yumi_a = 1'b0;

        // Carry ripples from slice 0 into slice 1
        exp3 = 256'd1 << 64;
        run_a("cross_slice", 256'hFFFF_FFFF_FFFF_FFFF, 256'd1, 1'b0, exp3, 1'b0);

        // Backpressure: DONE holds while inputs churn
        for (int i = 0; i < 10; i++) begin
            v_a = i[0];
            a_a = {8{32'(i * 32'h1357_9BDF)}};
            cin_a = i[1];
            tick();
            chk("bp_v", {255'd0, vo_a}, 256'd1);
            chk("bp_ready", {255'd0, ready_a}, 256'd0);
            chk("bp_sum", sum_a, exp3);
            chk("bp_cout", {255'd0, cout_a}, 256'd0);
        end
        v_a = 1'b0;
        yumi_a = 1'b1;
        tick();
        yumi_a = 1'b0;
        chk("bp_release_ready", {255'd0, ready_a}, 256'd1);
        chk("bp_release_v", {255'd0, vo_a}, 256'd0);

        // Async reset during the second BUSY cycle
        a_a = 256'd100; b_a = 256'd200; cin_a = 1'b0; v_a = 1'b1;
        tick();
        v_a = 1'b0;
        tick();
        chk("pre_rst_busy", {255'd0, ready_a}, 256'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {255'd0, ready_a}, 256'd1);
        chk("arst_v", {255'd0, vo_a}, 256'd0);
        chk("arst_sum", sum_a, 256'd0);
        chk("arst_cout", {255'd0, cout_a}, 256'd0);
        #1 rst_n = 1'b1;
        run_a("post_rst", 256'd5, 256'd7, 1'b0, 256'd12, 1'b0);
        yumi_a = 1'b1;
        tick();
        yumi_a = 1'b0;
        chk("post_rst_idle", {255'd0, ready_a}, 256'd1);

        // Single-slice configuration
        a_b = 8'hFF; b_b = 8'h01; cin_b = 1'b1; v_b = 1'b1;
        tick();
        v_b = 1'b0;
        chk("b_busy_v", {255'd0, vo_b}, 256'd0);
        chk("b_busy_ready", {255'd0, ready_b}, 256'd0);
        tick();
        chk("b_done_v", {255'd0, vo_b}, 256'd1);
        chk("b_sum", {248'd0, sum_b}, 256'h01);
        chk("b_cout", {255'd0, cout_b}, 256'd1);
        yumi_b = 1'b1;
        tick();
        yumi_b = 1'b0;
        chk("b_idle", {255'd0, ready_b}, 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
